// File: rtl/spi_master_arbiter_pkg.sv
// Shared types and constants for the SPI master arbiter.
// Build option: SPI_ARB_REG_CFG_EN adds the per-requester config-register write.
package spi_master_arbiter_pkg;
  localparam int data_width_c     = 8;
  localparam int reg_addr_width_c = 8;
  localparam int reg_din_width_c  = 8;
  localparam int bits_of_slaves_c = 4;
  localparam int slave_addr_w_c   = $clog2(bits_of_slaves_c);

  typedef enum logic [2:0] {IDLE, CFG_WR, CFG_WAIT, FEED, DRAIN} spi_arb_state_t;
endpackage

// File: rtl/spi_master_arbiter_if.sv
// Client-side and SPI-master-side signals of the arbiter.
// Build option: SPI_ARB_REG_CFG_EN adds req_cfg and rx_err.
interface spi_master_arbiter_if
  import spi_master_arbiter_pkg::*;
#(
  parameter int num_req_g = 4
);
  logic [num_req_g-1:0]                     req, req_last, req_pop, gnt, rx_valid;
  logic [num_req_g-1:0][data_width_c-1:0]   req_data;
  logic [num_req_g-1:0][slave_addr_w_c-1:0] req_addr;
  logic [data_width_c-1:0]                  rx_data, fifo_din, dout;
  logic                                     fifo_req_data, fifo_din_valid, fifo_empty;
  logic                                     busy, dout_valid;
  logic [slave_addr_w_c-1:0]                spi_slave_addr;
  logic [reg_addr_width_c-1:0]              reg_addr;
  logic [reg_din_width_c-1:0]               reg_din;
  logic                                     reg_din_val, reg_ack, reg_err;
`ifdef SPI_ARB_REG_CFG_EN
  logic [num_req_g-1:0][reg_din_width_c-1:0] req_cfg;
  logic [num_req_g-1:0]                      rx_err;
`endif

  // master: the arbiter; slave: clients plus SPI master core
  modport master (
    input  req, req_data, req_last, req_addr, fifo_req_data, busy, dout, dout_valid,
           reg_ack, reg_err,
`ifdef SPI_ARB_REG_CFG_EN
    input  req_cfg,
    output rx_err,
`endif
    output req_pop, gnt, rx_data, rx_valid, fifo_din, fifo_din_valid, fifo_empty,
           spi_slave_addr, reg_addr, reg_din, reg_din_val
  );

  modport slave (
    output req, req_data, req_last, req_addr, fifo_req_data, busy, dout, dout_valid,
           reg_ack, reg_err,
`ifdef SPI_ARB_REG_CFG_EN
    output req_cfg,
    input  rx_err,
`endif
    input  req_pop, gnt, rx_data, rx_valid, fifo_din, fifo_din_valid, fifo_empty,
           spi_slave_addr, reg_addr, reg_din, reg_din_val
  );
endinterface

// File: rtl/spi_master_arbiter_picker.sv
// Combinational round-robin pick: first set request after ptr_i, wrapping.
module rr_priority_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [IW-1:0] j;

  // Walk farthest-to-nearest so the nearest requester after the pointer wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = N-1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + 1 + k) % N);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master across requesters for whole bursts.
// Build option: SPI_ARB_REG_CFG_EN writes a per-requester config word before each burst.
module spi_master_arbiter
  import spi_master_arbiter_pkg::*;
#(
  parameter int num_req_g      = 4,
  parameter int cfg_reg_addr_g = 0
) (
  input logic                  clk,
  input logic                  rst,
  spi_master_arbiter_if.master bus
);
  localparam int IW = $clog2(num_req_g);

  spi_arb_state_t              state_q, state_d;
  logic [IW-1:0]               g_q, g_d, ptr_q, ptr_d;
  logic [num_req_g-1:0]        gnt_q, gnt_d, pop_q, pop_d, rxv_q, rxv_d, g_oh;
  logic [data_width_c-1:0]     din_q, din_d, rxd_q, rxd_d;
  logic                        dinv_q, dinv_d, seen_q, seen_d;
  logic [slave_addr_w_c-1:0]   sa_q, sa_d;
  logic [num_req_g-1:0]        pick_gnt;
  logic [IW-1:0]               pick_idx;
  logic                        pick_vld;
`ifdef SPI_ARB_REG_CFG_EN
  logic [num_req_g-1:0]        rxe_q, rxe_d;
`endif

  rr_priority_picker #(.N(num_req_g)) u_pick (
    .req_i(bus.req), .ptr_i(ptr_q), .gnt_o(pick_gnt), .idx_o(pick_idx), .vld_o(pick_vld)
  );

  assign g_oh = num_req_g'(1) << g_q;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    pop_d   = '0;
    din_d   = din_q;
    dinv_d  = 1'b0;
    sa_d    = sa_q;
    seen_d  = seen_q;
    rxv_d   = '0;
    rxd_d   = rxd_q;
`ifdef SPI_ARB_REG_CFG_EN
    rxe_d   = '0;
`endif
    unique case (state_q)
      IDLE: if (pick_vld) begin
        g_d   = pick_idx;
        gnt_d = pick_gnt;
        sa_d  = bus.req_addr[pick_idx];
`ifdef SPI_ARB_REG_CFG_EN
        state_d = CFG_WR;
`else
        state_d = FEED;
`endif
      end
`ifdef SPI_ARB_REG_CFG_EN
      CFG_WR:   state_d = CFG_WAIT;
      CFG_WAIT: if (bus.reg_ack) begin
        if (bus.reg_err) begin
          rxe_d   = g_oh;
          gnt_d   = '0;
          ptr_d   = g_q;
          state_d = IDLE;
        end else begin
          state_d = FEED;
        end
      end
`endif
      // A request in the cycle right after a pop would see the old FWFT word.
      FEED: if (bus.fifo_req_data && !dinv_q) begin
        din_d  = bus.req_data[g_q];
        dinv_d = 1'b1;
        pop_d  = g_oh;
        if (bus.req_last[g_q]) begin
          seen_d  = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          gnt_d   = '0;
          ptr_d   = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == FEED || state_q == DRAIN) && bus.dout_valid) begin
      rxv_d = g_oh;
      rxd_d = bus.dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IW'(num_req_g - 1);
      gnt_q   <= '0;
      pop_q   <= '0;
      din_q   <= '0;
      dinv_q  <= 1'b0;
      sa_q    <= '0;
      seen_q  <= 1'b0;
      rxv_q   <= '0;
      rxd_q   <= '0;
`ifdef SPI_ARB_REG_CFG_EN
      rxe_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      pop_q   <= pop_d;
      din_q   <= din_d;
      dinv_q  <= dinv_d;
      sa_q    <= sa_d;
      seen_q  <= seen_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
`ifdef SPI_ARB_REG_CFG_EN
      rxe_q   <= rxe_d;
`endif
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.req_pop        = pop_q;
  assign bus.fifo_din       = din_q;
  assign bus.fifo_din_valid = dinv_q;
  assign bus.fifo_empty     = (state_q != FEED);
  assign bus.spi_slave_addr = sa_q;
  assign bus.rx_valid       = rxv_q;
  assign bus.rx_data        = rxd_q;

`ifdef SPI_ARB_REG_CFG_EN
  assign bus.reg_din_val = (state_q == CFG_WR);
  assign bus.reg_addr    = (state_q == CFG_WR) ? reg_addr_width_c'(cfg_reg_addr_g) : '0;
  assign bus.reg_din     = (state_q == CFG_WR) ? bus.req_cfg[g_q] : '0;
  assign bus.rx_err      = rxe_q;
`else
  assign bus.reg_din_val = 1'b0;
  assign bus.reg_addr    = '0;
  assign bus.reg_din     = '0;
  logic unused_cfg;
  assign unused_cfg = ^{bus.reg_ack, bus.reg_err};
`endif
endmodule
